// File: rtl/mod_74x597_serializer_if.sv
// Bus bundle for the 74x597-style serializer: parallel/serial inputs, manual
// strobes, frame request, and serial/status outputs.
interface mod_74x597_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] D;
    logic             SER;
    logic             LATCH;
    logic             LOAD;
    logic             SHIFT;
    logic             START;
    logic             QH;
    logic [WIDTH-1:0] STORE;
    logic             BUSY;
    logic             DONE;

    modport master (
        output D, SER, LATCH, LOAD, SHIFT, START,
        input  QH, STORE, BUSY, DONE
    );

    modport slave (
        input  D, SER, LATCH, LOAD, SHIFT, START,
        output QH, STORE, BUSY, DONE
    );
endinterface

// File: rtl/mod_74x597_serializer.sv
// Storage register + shift register pair (74x597 style) with an automatic
// START-driven frame controller that streams the storage value MSB-first.
module mod_74x597_serializer #(
    parameter int WIDTH = 8
) (
    input logic                     CLK,
    input logic                     CLR,
    mod_74x597_serializer_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD_S, SHIFT_S, DONE_S} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] store_q, store_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            state_q <= IDLE;
            store_q <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            store_q <= store_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE_S: state_d = bus.START ? LOAD_S : IDLE;
            LOAD_S:       state_d = SHIFT_S;
            SHIFT_S:      if (cnt_q == LAST) state_d = DONE_S;
            default:      state_d = IDLE;
        endcase
    end

    // Datapath next-state; manual strobes are only honoured outside a frame.
    always_comb begin
        store_d = store_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, DONE_S: begin
                if (bus.START) begin
                    store_d = bus.D;
                end else begin
                    if (bus.LATCH) store_d = bus.D;
                    if (bus.LOAD) begin
                        shift_d = store_q;
                    end else if (bus.SHIFT) begin
                        shift_d = {shift_q[WIDTH-2:0], bus.SER};
                    end
                end
            end
            LOAD_S: begin
                shift_d = store_q;
                cnt_d   = '0;
            end
            SHIFT_S: begin
                shift_d = {shift_q[WIDTH-2:0], bus.SER};
                if (cnt_q != LAST) cnt_d = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_d = (state_d == LOAD_S) || (state_d == SHIFT_S);
        done_d = (state_d == DONE_S);
    end

    assign bus.QH    = shift_q[WIDTH-1];
    assign bus.STORE = store_q;
    assign bus.BUSY  = busy_q;
    assign bus.DONE  = done_q;
endmodule

// File: doc/mod_74x597_serializer.md
# mod_74x597_serializer

Synchronous 8-bit parallel-in/serial-out register pair, modelled on the 74x597 storage-register-plus-shift-register arrangement, with an added frame controller. It sits directly downstream of the dual 4-bit counter stage: the counter's two nibbles (high nibble from bank 2, low nibble from bank 1) drive D. It is used to capture a count snapshot and stream it out MSB-first on a single wire. The block supports manual chip-style control (latch/load/shift) and an automatic START-driven frame with BUSY/DONE status.

## Interface
- WIDTH, 8: register width in bits; must be ≥ 2; bit counter width is $clog2(WIDTH).
- CLK  in  1  clock; all state changes on the rising edge.
- CLR  in  1  synchronous, active-high reset; dominates every other input.
- D  in  WIDTH  parallel data; {Q2,Q1} from the counter stage.
- SER  in  1  serial fill bit shifted into bit 0.
- LATCH  in  1  manual: storage register <= D.
- LOAD  in  1  manual: shift register <= storage register.
- SHIFT  in  1  manual: shift register <= {shift[WIDTH-2:0], SER}.
- START  in  1  request an automatic frame.
- QH  out  1  serial output = shift[WIDTH-1] (combinational from the register).
- STORE  out  WIDTH  current storage register contents.
- BUSY  out  1  high in LOAD_S and SHIFT_S states.
- DONE  out  1  one-cycle pulse when a frame completes.

## Operation
- Reset (CLR=1 at an edge): storage=0, shift=0, bit count=0, state=IDLE. Outputs are QH=0, STORE=0, BUSY=0, DONE=0.
- States are IDLE, LOAD_S, SHIFT_S and DONE_S. BUSY and DONE are registered decodes of the state.
- IDLE and DONE_S (manual mode):
  - LATCH, LOAD and SHIFT are all honoured.
  - LATCH is independent of LOAD and SHIFT.
  - If LATCH and LOAD are asserted together, the shift register receives the storage value from before the edge; the new D goes only to storage.
  - LOAD has priority over SHIFT.
- START in IDLE or DONE_S:
  - storage <= D; next state is LOAD_S.
  - Manual inputs are ignored on that edge.
- LOAD_S: shift <= storage, count <= 0; next state is SHIFT_S.
- SHIFT_S:
  - If count < WIDTH-1: shift left with SER fill, count++.
  - If count == WIDTH-1: shift once more; next state is DONE_S.
- DONE_S: lasts one cycle, then the state returns to IDLE unless START is sampled. If START is sampled, the next frame begins, giving back-to-back frames.
- While BUSY=1, START, LATCH, LOAD and SHIFT are ignored.
- CLR mid-frame aborts the frame: all state returns to reset values and no DONE pulse is produced.
- Arithmetic:
  - Shifts are logical.
  - The SER fill is taken from the edge on which the shift occurs.
  - The count never exceeds WIDTH-1.

## Timing
- Edge numbering: edge 1 is the edge that samples START.
  - After edge 1: state=LOAD_S, BUSY=1, STORE=D captured.
  - After edge 2: QH = D[WIDTH-1].
  - After edge 2+k (k = 0..WIDTH-1): QH = D[WIDTH-1-k].
  - After edge WIDTH+2: DONE=1 and BUSY=0 for exactly one cycle.
- For WIDTH=8:
  - BUSY is high in cycles 1–9.
  - D[7..0] appear on QH in cycles 2–9.
  - DONE is high in cycle 10.
  - A frame repeats every 10 cycles with START held high.
- Manual ops take effect on the edge where they are sampled; the result is visible in the following cycle. There is no added latency.
- There is no combinational path from any input to any output.

## Test plan
- Reset: hold CLR=1 for 2 edges with D=8'hFF, START=1, LATCH=1 -> QH=0, STORE=0, BUSY=0, DONE=0; after CLR falls, START begins a frame on the next edge.
- Frame: D=8'hA5, one-cycle START -> QH = 1,0,1,0,0,1,0,1 in cycles 2–9; BUSY high in cycles 1–9; DONE high only in cycle 10; STORE=8'hA5.
- Manual path:
  - LATCH with D=8'h3C, then LOAD, then 8×SHIFT with SER=1 -> QH = 0,0,1,1,1,1,0,0, then 1 thereafter.
  - Then LATCH+LOAD together with D=8'hFF -> shift holds 8'h3C and STORE=8'hFF.
- Abort: START with D=8'hFF, assert CLR in cycle 5 -> after that edge everything is 0, BUSY=0, no DONE pulse; a new START afterwards runs a full clean frame.
- Back-to-back and ignore rules:
  - START held high, D changed from 8'h12 to 8'h34 during frame 1 -> frame 2 begins on the DONE_S edge and serializes 8'h34.
  - LATCH/LOAD/SHIFT pulses during BUSY leave STORE and the QH sequence unchanged.
- Counter integration: drive D from the dual 4-bit counter stage clocked each cycle and START every 10 cycles -> each serialized frame equals {Q2,Q1} as sampled on that frame's START edge.
